// File: rtl/quantizer_iter.sv
// Iterative fp32 activation quantizer: index = round(act/max * (2^IDX_W-1)) computed with a
// restoring divider, one quotient bit per cycle, behind valid/ready handshakes on both sides.
module quantizer_iter #(
  parameter int IDX_W      = 8,
  parameter int ROUND_MODE = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_valid,
  output logic             o_in_ready,
  input  logic [31:0]      i_max,
  input  logic [31:0]      i_activation,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [IDX_W-1:0] o_index,
  output logic             o_sat,
  output logic             o_err,
  output logic [1:0]       o_dbg_state
);

  // Handshake: an input is taken on a rising edge where i_valid && o_in_ready; a result is
  // taken on a rising edge where o_valid && i_ready. o_valid and the result hold until taken.

  localparam int NUM_W  = 25 + IDX_W;
  localparam int DW     = NUM_W + IDX_W;
  localparam int LEVELS = (1 << IDX_W) - 1;

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_DIV, S_DONE} state_t;

  state_t             state_q;
  logic [31:0]        act_q, max_q;
  logic [DW-1:0]      rem_q, dsh_q;
  logic [IDX_W:0]     q2_q;
  logic [3:0]         cnt_q;
  logic               err_pend_q, sat_pend_q;
  logic               in_ready_q, valid_q, sat_q, err_q;
  logic [IDX_W-1:0]   index_q;

  logic [7:0]         ea, em;
  logic [23:0]        ma, mm;
  logic               max_bad_d, act_nan_d, act_nonpos_d, act_ge_d, early_d;
  logic [3:0]         sh_d;
  logic [NUM_W-1:0]   num_d;
  logic [DW-1:0]      dsh_init_d;
  logic               bit_d;
  logic [DW-1:0]      rem_sub_d;
  logic [IDX_W+1:0]   rnd_d;
  logic               clip_d;

  always_comb begin
    ea           = act_q[30:23];
    em           = max_q[30:23];
    ma           = {1'b1, act_q[22:0]};
    mm           = {1'b1, max_q[22:0]};
    max_bad_d    = max_q[31] || (em == 8'h00) || (em == 8'hFF);
    act_nan_d    = (ea == 8'hFF) && (act_q[22:0] != 23'd0);
    act_nonpos_d = act_q[31] || (ea == 8'h00);
    // Both operands positive here, so raw bit patterns order like the values (+Inf included).
    act_ge_d     = act_q[30:0] >= max_q[30:0];
    early_d      = (em > ea) && ((em - ea) >= 8'(IDX_W + 2));
    sh_d         = 4'(em - ea);
    num_d        = (NUM_W'(ma) * NUM_W'(LEVELS)) << 1;
    dsh_init_d   = (DW'(mm) << sh_d) << IDX_W;
    bit_d        = rem_q >= dsh_q;
    rem_sub_d    = rem_q - dsh_q;
    if (ROUND_MODE != 0) rnd_d = ({1'b0, q2_q} + (IDX_W+2)'(1)) >> 1;
    else                 rnd_d = {1'b0, q2_q} >> 1;
    clip_d       = rnd_d > (IDX_W+2)'(LEVELS);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      act_q      <= '0;
      max_q      <= '0;
      rem_q      <= '0;
      dsh_q      <= '0;
      q2_q       <= '0;
      cnt_q      <= '0;
      err_pend_q <= 1'b0;
      sat_pend_q <= 1'b0;
      in_ready_q <= 1'b1;
      valid_q    <= 1'b0;
      index_q    <= '0;
      sat_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_valid) begin
            act_q      <= i_activation;
            max_q      <= i_max;
            in_ready_q <= 1'b0;
            state_q    <= S_PREP;
          end
        end
        S_PREP: begin
          err_pend_q <= 1'b0;
          sat_pend_q <= 1'b0;
          q2_q       <= '0;
          if (max_bad_d || act_nan_d) begin
            err_pend_q <= 1'b1;
            state_q    <= S_DONE;
          end else if (act_nonpos_d || early_d) begin
            state_q    <= S_DONE;
          end else if (act_ge_d) begin
            sat_pend_q <= 1'b1;
            state_q    <= S_DONE;
          end else begin
            rem_q   <= DW'(num_d);
            dsh_q   <= dsh_init_d;
            cnt_q   <= 4'(IDX_W);
            state_q <= S_DIV;
          end
        end
        S_DIV: begin
          if (bit_d) rem_q <= rem_sub_d;
          q2_q  <= {q2_q[IDX_W-1:0], bit_d};
          dsh_q <= dsh_q >> 1;
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd0) state_q <= S_DONE;
        end
        default: begin
          // First DONE cycle forms the result; it is then held until taken.
          if (!valid_q) begin
            valid_q <= 1'b1;
            if (err_pend_q) begin
              index_q <= '0;
              sat_q   <= 1'b0;
              err_q   <= 1'b1;
            end else if (sat_pend_q || clip_d) begin
              index_q <= IDX_W'(LEVELS);
              sat_q   <= 1'b1;
              err_q   <= 1'b0;
            end else begin
              index_q <= rnd_d[IDX_W-1:0];
              sat_q   <= 1'b0;
              err_q   <= 1'b0;
            end
          end else if (i_ready) begin
            valid_q    <= 1'b0;
            in_ready_q <= 1'b1;
            state_q    <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign o_in_ready  = in_ready_q;
  assign o_valid     = valid_q;
  assign o_index     = index_q;
  assign o_sat       = sat_q;
  assign o_err       = err_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_quantizer_iter.sv
// Bench for quantizer_iter: four instances (IDX_W 8 round/truncate, 4, 12) share one input
// stream; results are compared against a real-arithmetic model of act/max*LEVELS.
module tb_quantizer_iter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_valid, i_ready;
  logic [31:0] i_max, i_act;
  logic        rdy [4];
  logic        vld [4];
  logic        sat [4];
  logic        err [4];
  logic [1:0]  st  [4];
  logic [7:0]  idx_a, idx_b;
  logic [3:0]  idx_c;
  logic [11:0] idx_d;
  logic [15:0] res [4];

  int wid   [4] = '{8, 8, 4, 12};
  int rmode [4] = '{1, 0, 1, 1};

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  quantizer_iter #(.IDX_W(8), .ROUND_MODE(1)) u_w8r (
    .clk(clk), .reset_n(reset_n), .i_valid(i_valid), .o_in_ready(rdy[0]), .i_max(i_max),
    .i_activation(i_act), .o_valid(vld[0]), .i_ready(i_ready), .o_index(idx_a),
    .o_sat(sat[0]), .o_err(err[0]), .o_dbg_state(st[0]));
  quantizer_iter #(.IDX_W(8), .ROUND_MODE(0)) u_w8t (
    .clk(clk), .reset_n(reset_n), .i_valid(i_valid), .o_in_ready(rdy[1]), .i_max(i_max),
    .i_activation(i_act), .o_valid(vld[1]), .i_ready(i_ready), .o_index(idx_b),
    .o_sat(sat[1]), .o_err(err[1]), .o_dbg_state(st[1]));
  quantizer_iter #(.IDX_W(4), .ROUND_MODE(1)) u_w4 (
    .clk(clk), .reset_n(reset_n), .i_valid(i_valid), .o_in_ready(rdy[2]), .i_max(i_max),
    .i_activation(i_act), .o_valid(vld[2]), .i_ready(i_ready), .o_index(idx_c),
    .o_sat(sat[2]), .o_err(err[2]), .o_dbg_state(st[2]));
  quantizer_iter #(.IDX_W(12), .ROUND_MODE(1)) u_w12 (
    .clk(clk), .reset_n(reset_n), .i_valid(i_valid), .o_in_ready(rdy[3]), .i_max(i_max),
    .i_activation(i_act), .o_valid(vld[3]), .i_ready(i_ready), .o_index(idx_d),
    .o_sat(sat[3]), .o_err(err[3]), .o_dbg_state(st[3]));

  assign res[0] = {err[0], sat[0], 6'd0, idx_a};
  assign res[1] = {err[1], sat[1], 6'd0, idx_b};
  assign res[2] = {err[2], sat[2], 10'd0, idx_c};
  assign res[3] = {err[3], sat[3], 2'd0, idx_d};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
    end
  endtask

  function automatic real fp_val(input logic [31:0] b);
    real r;
    int  e;
    e = int'(b[30:23]);
    if (e == 0) return 0.0;
    r = real'({1'b1, b[22:0]});
    for (int i = 0; i < e - 150; i++) r = r * 2.0;
    for (int i = 0; i < 150 - e; i++) r = r / 2.0;
    return b[31] ? -r : r;
  endfunction

  // Result packed as {err, sat, index[13:0]}.
  function automatic logic [15:0] model(input logic [31:0] act, input logic [31:0] mx,
                                        input int w, input int rm);
    int  levels, idx;
    real a, m, x;
    levels = (1 << w) - 1;
    if (mx[31] || mx[30:23] == 8'h00 || mx[30:23] == 8'hFF) return 16'h8000;
    if (act[30:23] == 8'hFF && act[22:0] != 23'd0) return 16'h8000;
    a = fp_val(act);
    m = fp_val(mx);
    if (a <= 0.0) return 16'h0000;
    if (a >= m) return {2'b01, 14'(levels)};
    x = a * real'(levels) / m;
    idx = (rm != 0) ? int'($floor(x + 0.5)) : int'($floor(x));
    if (idx > levels) return {2'b01, 14'(levels)};
    return {2'b00, 14'(idx)};
  endfunction

  task automatic wait_idle(input string tag);
    int c;
    c = 0;
    while (!(rdy[0] && rdy[1] && rdy[2] && rdy[3]) && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    if (c >= 100) check({tag, "_idle_timeout"}, 32'(c), 32'd0);
  endtask

  task automatic run_txn(input logic [31:0] act, input logic [31:0] mx, input string tag,
                         input int exp_lat8);
    int          c;
    bit          done [4];
    int          lat  [4];
    logic [15:0] cap  [4];
    wait_idle(tag);
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(model(act, mx, wid[k], rmode[k]));
      done[k] = 1'b0;
      lat[k]  = 0;
      cap[k]  = '0;
    end
    i_act = act; i_max = mx; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0; i_act = $urandom; i_max = $urandom;
    c = 0;
    while (!(done[0] && done[1] && done[2] && done[3]) && c < 60) begin
      @(posedge clk); #1;
      c++;
      for (int k = 0; k < 4; k++)
        if (vld[k] && !done[k]) begin
          done[k] = 1'b1;
          lat[k]  = c;
          cap[k]  = res[k];
        end
    end
    for (int k = 0; k < 4; k++) begin
      if (!done[k]) check($sformatf("%s_w%0d_timeout", tag, k), 32'(c), 32'd0);
      check($sformatf("%s_dut%0d", tag, k), 32'(cap[k]), 32'(exp_q.pop_front()));
    end
    if (exp_lat8 > 0) check({tag, "_lat"}, 32'(lat[0]), 32'(exp_lat8));
  endtask

  initial begin
    logic [31:0] a, m;
    logic [7:0]  e;
    reset_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_max = '0; i_act = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++)
      check($sformatf("reset_dut%0d", k), {14'd0, rdy[k], vld[k], res[k]}, {14'd0, 2'b10, 16'd0});
    reset_n = 1'b1;

    run_txn(32'h41CC0000, 32'h437F0000, "mid_25p5", 11);
    run_txn(32'h43960000, 32'h437F0000, "over_300", 2);
    run_txn(32'hBF800000, 32'h437F0000, "neg_one", 2);
    run_txn(32'h80000000, 32'h437F0000, "neg_zero", 2);
    run_txn(32'h7F800000, 32'h437F0000, "pos_inf", 2);
    run_txn(32'h41CC0000, 32'h00000000, "max_zero", 2);
    run_txn(32'h41CC0000, 32'h7FC00000, "max_nan", 2);
    run_txn(32'h41CC0000, 32'hC37F0000, "max_neg", 2);
    run_txn(32'h7FC00000, 32'h437F0000, "act_nan", 2);
    run_txn(32'h3A83126F, 32'h437F0000, "tiny_act", 2);
    run_txn(32'h437F0000, 32'h437F0000, "act_eq_max", 2);
    run_txn(32'h437E0000, 32'h437F0000, "just_below", 11);

    // Back-pressure: result must hold, input side stays closed, extra requests vanish.
    wait_idle("bp");
    i_ready = 1'b0;
    i_act = 32'h41CC0000; i_max = 32'h437F0000; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    begin
      int c;
      c = 0;
      while (!(vld[0] && vld[1] && vld[2] && vld[3]) && c < 40) begin
        @(posedge clk); #1;
        c++;
      end
      if (c >= 40) check("bp_timeout", 32'(c), 32'd0);
    end
    for (int i = 0; i < 5; i++) begin
      i_valid = 1'b1; i_act = $urandom; i_max = 32'h3F800000;
      @(posedge clk); #1;
      check("bp_hold", 32'(res[0]), 32'(model(32'h41CC0000, 32'h437F0000, 8, 1)));
      check("bp_valid", 32'(vld[0]), 32'd1);
      check("bp_in_ready", 32'(rdy[0]), 32'd0);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 32'(vld[0]), 32'd0);
    check("bp_release_ready", 32'(rdy[0]), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("bp_no_extra", 32'(vld[0]), 32'd0);
    end

    // Reset pulse while the dividers are busy.
    wait_idle("rst");
    i_act = 32'h41CC0000; i_max = 32'h437F0000; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++)
      check($sformatf("rst_mid_dut%0d", k), {14'd0, rdy[k], vld[k], res[k]}, {14'd0, 2'b10, 16'd0});
    @(posedge clk); #1;
    reset_n = 1'b1;
    run_txn(32'h41CC0000, 32'h437F0000, "after_rst", 11);

    // Randomised positive pairs, exponents clustered so most go through the divider.
    for (int n = 0; n < 1000; n++) begin
      e = 8'($urandom_range(40, 200));
      m = {1'b0, e, 23'($urandom)};
      if ($urandom_range(0, 9) == 0)
        a = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
      else
        a = {1'b0, 8'(e - 8'($urandom_range(0, 16))), 23'($urandom)};
      run_txn(a, m, $sformatf("rand%0d", n), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
